// File: rtl/decode_stage.sv
// decode_stage: registered RV decode stage with skid buffer, illegal-opcode detection, flush and handshake counter
module decode_stage #(
  parameter int DATA_WIDTH = 64,
  parameter int PC_WIDTH   = 64,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_instr,
  input  logic [PC_WIDTH-1:0]   in_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [PC_WIDTH-1:0]   out_pc,
  output logic [6:0]            out_opcode,
  output logic [2:0]            out_func3,
  output logic                  out_func7,
  output logic [4:0]            out_rs1,
  output logic [4:0]            out_rs2,
  output logic [4:0]            out_rd,
  output logic [DATA_WIDTH-1:0] out_imme,
  output logic                  out_illegal,
  output logic [CNT_WIDTH-1:0]  out_count
);
  localparam logic [6:0] LUI = 7'h37, AUIPC = 7'h17, JAL = 7'h6F, JALR = 7'h67, B_TYPE = 7'h63;
  localparam logic [6:0] LOAD = 7'h03, STORE = 7'h23, I_TYPE = 7'h13, IW_TYPE = 7'h1B;
  localparam logic [6:0] R_TYPE = 7'h33, RW_TYPE = 7'h3B;
  typedef struct packed {
    logic [PC_WIDTH-1:0]   pc;
    logic [6:0]            opcode;
    logic [2:0]            func3;
    logic                  func7;
    logic [4:0]            rs1;
    logic [4:0]            rs2;
    logic [4:0]            rd;
    logic [DATA_WIDTH-1:0] imme;
    logic                  illegal;
  } entry_t;
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  state_t state, state_nx;
  entry_t dec, out_r, skid_r;
  logic [6:0] op;
  logic illegal, skid_valid, in_fire, out_fire;
  logic [31:0] imm32;
  // Every format's immediate fits a signed 32-bit value; widen to XLEN afterwards.
  always_comb begin
    op = in_instr[6:0];
    illegal = !(op inside {LUI, AUIPC, JAL, JALR, B_TYPE, LOAD, STORE, I_TYPE, IW_TYPE, R_TYPE, RW_TYPE})
      || (DATA_WIDTH == 32 && (op == IW_TYPE || op == RW_TYPE));
    imm32 = illegal ? '0
      : op inside {JALR, LOAD, I_TYPE, IW_TYPE} ? {{20{in_instr[31]}}, in_instr[31:20]}
      : op inside {LUI, AUIPC} ? {in_instr[31:12], 12'b0}
      : op == JAL ? {{12{in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0}
      : op == B_TYPE ? {{20{in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0}
      : op == STORE ? {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]}
      : '0;
    dec = '{pc: in_pc, opcode: op, func3: in_instr[14:12], func7: in_instr[30],
            rs1: in_instr[19:15], rs2: in_instr[24:20], rd: in_instr[11:7],
            imme: DATA_WIDTH'($signed(imm32)), illegal: illegal};
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= EMPTY;
    else state <= state_nx;
  always_comb begin
    state_nx = flush ? EMPTY
      : state == EMPTY ? (in_valid ? ONE : EMPTY)
      : state == ONE ? (in_fire && !out_ready ? FULL : !in_fire && out_ready ? EMPTY : ONE)
      : (out_ready ? ONE : FULL);
  end
  always_comb begin
    out_valid = state != EMPTY;
    skid_valid = state == FULL;
    in_ready = !skid_valid;
    in_fire = in_valid && in_ready;
    out_fire = out_valid && out_ready;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      out_r <= '0;
      skid_r <= '0;
      out_count <= '0;
    end else begin
      if (skid_valid && out_ready) out_r <= skid_r;
      else if (in_fire && (!out_valid || out_ready)) out_r <= dec;
      if (in_fire && out_valid && !out_ready) skid_r <= dec;
      out_count <= out_count + CNT_WIDTH'(out_fire);
    end
  assign out_pc = out_r.pc;
  assign out_opcode = out_r.opcode;
  assign out_func3 = out_r.func3;
  assign out_func7 = out_r.func7;
  assign out_rs1 = out_r.rs1;
  assign out_rs2 = out_r.rs2;
  assign out_rd = out_r.rd;
  assign out_imme = out_r.imme;
  assign out_illegal = out_r.illegal;
endmodule

// File: doc/decode_stage.md
# decode_stage

Registered, flow-controlled RV decode stage sitting between the fetch buffer and the issue/register-read stage. It accepts one 32-bit instruction per cycle over a valid/ready handshake and extracts opcode, func3, func7 bit, register indices and the sign-extended immediate for the I/U/J/B/S formats. Results are presented one cycle later on a registered output port, backed by a one-entry skid buffer so neither `in_ready` nor `out_valid` has a combinational path from the other side. Generalises the combinational decoder with the following:

- configurable XLEN
- illegal-opcode detection
- pipeline flush
- a retired-decode counter

## Interface
Parameters:
- `DATA_WIDTH`, 64: XLEN. Legal values are 32 and 64. It sets the immediate width and whether `Iw_type`/`Rw_type` are legal.
- `PC_WIDTH`, 64: width of the PC carried alongside the instruction.
- `CNT_WIDTH`, 32: width of the decoded-instruction counter.

Ports:
- `clk`, in, 1: single clock. All state changes on the rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `flush`, in, 1: synchronous kill of all held entries.
- `in_valid`, in, 1: upstream holds a valid instruction.
- `in_ready`, out, 1: stage can accept an instruction.
- `in_instr`, in, 32: raw instruction.
- `in_pc`, in, `PC_WIDTH`: PC of `in_instr`.
- `out_valid`, out, 1: decoded entry present.
- `out_ready`, in, 1: downstream accepts the entry.
- `out_pc`, out, `PC_WIDTH`: PC of the decoded entry.
- `out_opcode`, out, 7: instr[6:0].
- `out_func3`, out, 3: instr[14:12].
- `out_func7`, out, 1: instr[30].
- `out_rs1`, out, 5: instr[19:15].
- `out_rs2`, out, 5: instr[24:20].
- `out_rd`, out, 5: instr[11:7].
- `out_imme`, out, `DATA_WIDTH`: sign-extended immediate.
- `out_illegal`, out, 1: entry is an illegal instruction.
- `out_count`, out, `CNT_WIDTH`: number of output handshakes since reset.

## Operation
- **Decode** is combinational on `in_instr` and captured at acceptance.
  - I-format (`jalr`, `load`, `I_type`, `Iw_type`): immediate is {sext instr[31:20]}.
  - U-format (`lui`, `auipc`): {sext instr[31:12], 12'b0}. At `DATA_WIDTH`=32 there is no extension beyond bit 31.
  - J-format (`jal`): {sext instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}.
  - B-format (`B_type`): {sext instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}.
  - S-format (`store`): {sext instr[31:25], instr[11:7]}.
  - All other opcodes: immediate is 0.
- **Illegal detection.** `out_illegal`=1 when any of the following holds. An illegal entry still carries its raw fields, with the immediate forced to 0.
  - instr[1:0] != 2'b11.
  - The opcode is outside {`lui`, `auipc`, `jal`, `jalr`, `B_type`, `load`, `store`, `I_type`, `Iw_type`, `R_type`, `Rw_type`}.
  - `DATA_WIDTH`=32 and the opcode is `Iw_type` or `Rw_type`.
- **Storage** is two entries: the output register (OUT) and the skid register (SKID).
- **State machine** (`out_valid`, `skid_valid`):
  - **EMPTY (0,0):** `in_valid` moves to ONE.
  - **ONE (1,0):** transitions depend on the handshakes this cycle.
    - in and out both fire: stay in ONE, and OUT takes the new entry.
    - in only: go to FULL, with the new entry in SKID.
    - out only: go to EMPTY.
  - **FULL (1,1):** `out_ready` moves SKID into OUT and goes to ONE. `in_ready`=0, so no acceptance is possible.
- `in_ready` = !`skid_valid`. It is registered state and has no path from `out_ready`.
- **Flush** has priority over everything. On the next edge both valids clear and any `in_valid` that cycle is dropped. The output handshake in the flush cycle still counts if `out_valid`&&`out_ready`.
- **Counter.** `out_count` increments by 1 on each `out_valid`&&`out_ready` and wraps modulo 2^`CNT_WIDTH`. `flush` does not reset it.

## Timing
- Latency is 1 cycle: an instruction accepted at edge N is on the outputs after edge N.
- Sustained throughput is 1 instruction/cycle with `out_ready` held at 1.
- Out-handshake rules:
  - Once `out_valid`=1, the output fields stay stable until the handshake completes or a flush occurs.
  - `out_valid` never drops without a handshake, except on flush or reset.
- Data is taken only when `in_valid`&&`in_ready`. Upstream must hold its data stable while stalled.
- Reset, asynchronous on `rst` going high and effective immediately, even mid-transfer. All held entries are lost.
  - `out_valid`=0 and `skid_valid`=0, giving `in_ready`=1.
  - `out_count`=0.
  - All `out_*` data fields are 0.
- Release of `rst` is assumed synchronous to `clk` by the reset bridge upstream.

## Test plan
- **Immediates.** Send 0xFFF00093 (addi x1,x0,-1), 0x800002B7 (lui x5,0x80000) and 0xFFDFF06F (jal x0,-4) with `out_ready`=1.
  - addi: imme=0xFFFF_FFFF_FFFF_FFFF, rd=1.
  - lui: imme=0xFFFF_FFFF_8000_0000, rd=5.
  - jal: imme=-4.
  - Each result appears 1 cycle after acceptance, with `out_count`=3 at the end.
- **Backpressure.** `out_ready`=0 while 3 instructions with PCs 0x100, 0x104, 0x108 are offered back-to-back.
  - 0x100 is in OUT and 0x104 in SKID, and `in_ready`=0 at the third cycle.
  - After `out_ready`=1, the outputs come out in order 0x100, 0x104, 0x108 with nothing lost or duplicated.
- **Illegal.** At `DATA_WIDTH`=32, send 0x0000001B: `out_illegal`=1 and imme=0. Send 0x00000000: `out_illegal`=1. At `DATA_WIDTH`=64, 0x0010009B gives `out_illegal`=0 and imme=1.
- **Flush.** Fill the FULL state, then assert `flush` together with `in_valid`. Next cycle `out_valid`=0, `in_ready`=1, and the flushed and offered instructions never appear.
- **Reset mid-transfer.** Pulse `rst` mid-cycle in the FULL state. Outputs go to 0 and `in_ready`=1 immediately, without waiting for a clock edge, and `out_count`=0.
- **Counter wrap.** At `CNT_WIDTH`=4, perform 17 handshakes; `out_count`=1.
